// File: rtl/dice_disp_pkg.sv
// Shared types and constants for the dice_tid_dispatcher slice.
package dice_disp_pkg;

  localparam int unsigned NUM_TID    = 512;
  localparam int unsigned TID_WIDTH  = $clog2(NUM_TID);
  localparam int unsigned PERF_CNT_W = 32;

  typedef logic [TID_WIDTH-1:0] tid_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } disp_state_e;

endpackage

// File: rtl/dice_tid_dispatcher_if.sv
// Thread-issue handshake: the dispatcher offers a TID with coordinates, the consumer accepts it.
interface dice_tid_dispatcher_if #(
  parameter int unsigned TID_WIDTH = dice_disp_pkg::TID_WIDTH
);
  logic [TID_WIDTH-1:0] dispatch_tid;
  logic [TID_WIDTH-1:0] tid_x;
  logic [TID_WIDTH-1:0] tid_y;
  logic [TID_WIDTH-1:0] tid_z;
  logic                 tid_valid;
  logic                 tid_ready;

  modport master (
    output dispatch_tid, tid_x, tid_y, tid_z, tid_valid,
    input  tid_ready
  );

  modport slave (
    input  dispatch_tid, tid_x, tid_y, tid_z, tid_valid,
    output tid_ready
  );
endinterface

// File: rtl/dice_tid_counter3d.sv
// x/y/z wrap-and-carry counter; x increments fastest, z wraps silently at its limit.
module dice_tid_counter3d #(
  parameter int unsigned W = dice_disp_pkg::TID_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  input  logic [W-1:0] lim_x,
  input  logic [W-1:0] lim_y,
  input  logic [W-1:0] lim_z,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] z
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x <= '0;
      y <= '0;
      z <= '0;
    end else if (inc) begin
      if (x < lim_x) begin
        x <= x + 1'b1;
      end else begin
        x <= '0;
        if (y < lim_y) begin
          y <= y + 1'b1;
        end else begin
          y <= '0;
          z <= (z < lim_z) ? z + 1'b1 : '0;
        end
      end
    end
  end

endmodule

// File: rtl/dice_tid_dispatcher.sv
// Valid/ready thread-ID issuer for one CTA; optional perf counters under DICE_DISP_PERF_CNT_EN.
module dice_tid_dispatcher
  import dice_disp_pkg::*;
#(
  parameter int unsigned NUM_TID   = 512,
  parameter int unsigned TID_WIDTH = $clog2(NUM_TID)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clr,
  input  logic [TID_WIDTH-1:0]  max_tid,
  input  logic [TID_WIDTH-1:0]  ntid_x,
  input  logic [TID_WIDTH-1:0]  ntid_y,
  input  logic [TID_WIDTH-1:0]  ntid_z,
`ifdef DICE_DISP_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] perf_stall_cycles,
  output logic [PERF_CNT_W-1:0] perf_active_cycles,
`endif
  dice_tid_dispatcher_if.master tid_if,
  output logic                  done
);

  disp_state_e          state, state_n;
  logic [TID_WIDTH-1:0] tid, tid_n;
  logic                 valid, valid_n, done_n;
  logic                 load, adv;
  logic [TID_WIDTH-1:0] max_r, lim_x, lim_y, lim_z;
  logic [TID_WIDTH-1:0] cx, cy, cz;
  logic                 hs;

  assign hs = valid & tid_if.tid_ready;

  always_comb begin
    state_n = state;
    tid_n   = tid;
    valid_n = valid;
    done_n  = done;
    load    = 1'b0;
    adv     = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_n = RUN;
          valid_n = 1'b1;
          load    = 1'b1;
        end
      end
      RUN: begin
        // enable only gates the next offer; a handshake this cycle completes regardless
        if (hs && tid == max_r) begin
          state_n = DONE;
          valid_n = 1'b0;
          done_n  = 1'b1;
        end else begin
          if (hs) begin
            adv   = 1'b1;
            tid_n = tid + 1'b1;
          end
          valid_n = enable;
        end
      end
      DONE: begin
        valid_n = 1'b0;
        done_n  = 1'b1;
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
        done_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state <= IDLE;
      tid   <= '0;
      valid <= 1'b0;
      done  <= 1'b0;
      max_r <= '0;
      lim_x <= '0;
      lim_y <= '0;
      lim_z <= '0;
    end else begin
      state <= state_n;
      tid   <= tid_n;
      valid <= valid_n;
      done  <= done_n;
      if (load) begin
        max_r <= max_tid;
        lim_x <= ntid_x;
        lim_y <= ntid_y;
        lim_z <= ntid_z;
      end
    end
  end

  dice_tid_counter3d #(.W(TID_WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clr || state == IDLE),
    .inc   (adv),
    .lim_x (lim_x),
    .lim_y (lim_y),
    .lim_z (lim_z),
    .x     (cx),
    .y     (cy),
    .z     (cz)
  );

  assign tid_if.dispatch_tid = tid;
  assign tid_if.tid_x        = cx;
  assign tid_if.tid_y        = cy;
  assign tid_if.tid_z        = cz;
  assign tid_if.tid_valid    = valid;

`ifdef DICE_DISP_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      perf_stall_cycles  <= '0;
      perf_active_cycles <= '0;
    end else begin
      if (valid && !tid_if.tid_ready && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (state == RUN && perf_active_cycles != '1)
        perf_active_cycles <= perf_active_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dice_tid_dispatcher.sv
// Directed self-checking bench for dice_tid_dispatcher; honours DICE_DISP_PERF_CNT_EN.
module tb_dice_tid_dispatcher;
  import dice_disp_pkg::*;

  logic clk = 1'b0;
  logic rst, enable, clr;
  tid_t max_tid, ntid_x, ntid_y, ntid_z;
  logic done;
`ifdef DICE_DISP_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] perf_stall_cycles, perf_active_cycles;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  dice_tid_dispatcher_if #(.TID_WIDTH(TID_WIDTH)) tif ();

  dice_tid_dispatcher #(.NUM_TID(NUM_TID), .TID_WIDTH(TID_WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .clr     (clr),
    .max_tid (max_tid),
    .ntid_x  (ntid_x),
    .ntid_y  (ntid_y),
    .ntid_z  (ntid_z),
`ifdef DICE_DISP_PERF_CNT_EN
    .perf_stall_cycles  (perf_stall_cycles),
    .perf_active_cycles (perf_active_cycles),
`endif
    .tid_if  (tif.master),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic check_offer(input string tag, input int unsigned t, input int unsigned x,
                             input int unsigned y, input int unsigned z, input logic v);
    check({tag, ".valid"}, 32'(tif.tid_valid), 32'(v));
    check({tag, ".tid"},   32'(tif.dispatch_tid), t);
    check({tag, ".x"},     32'(tif.tid_x), x);
    check({tag, ".y"},     32'(tif.tid_y), y);
    check({tag, ".z"},     32'(tif.tid_z), z);
  endtask

  task automatic check_idle(input string tag);
    check_offer(tag, 0, 0, 0, 0, 1'b0);
    check({tag, ".done"}, 32'(done), 0);
  endtask

  task automatic configure(input int unsigned m, input int unsigned nx,
                           input int unsigned ny, input int unsigned nz);
    max_tid = tid_t'(m);
    ntid_x  = tid_t'(nx);
    ntid_y  = tid_t'(ny);
    ntid_z  = tid_t'(nz);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; enable = 1'b0;
    tif.tid_ready = 1'b0;
    configure(0, 0, 0, 0);
    step(2);
    check_idle("reset");
`ifdef DICE_DISP_PERF_CNT_EN
    check("reset.perf_stall", perf_stall_cycles, 0);
    check("reset.perf_active", perf_active_cycles, 0);
`endif
    rst = 1'b0;

    // 1-D run over 256 threads at full throughput
    configure(255, 255, 0, 0);
    tif.tid_ready = 1'b1;
    enable = 1'b1;
    step();
    for (int unsigned i = 0; i < 256; i++) begin
      check_offer($sformatf("lin%0d", i), i, i, 0, 0, 1'b1);
      check($sformatf("lin%0d.done", i), 32'(done), 0);
      step();
    end
    check("lin.done", 32'(done), 1);
    check("lin.valid_end", 32'(tif.tid_valid), 0);
    step(2);
    check("lin.done_sticky", 32'(done), 1);
    check("lin.valid_sticky", 32'(tif.tid_valid), 0);
    do_clr();
    check_idle("lin.clr");

    // 4x2x2 grid; config inputs change mid-run and must be ignored
    enable = 1'b0;
    step();
    configure(15, 3, 1, 1);
    enable = 1'b1;
    step();
    for (int unsigned i = 0; i < 16; i++) begin
      check_offer($sformatf("g3d%0d", i), i, i % 4, (i / 4) % 2, (i / 8) % 2, 1'b1);
      if (i == 2) configure(3, 0, 0, 0);
      step();
    end
    check("g3d.done", 32'(done), 1);
    check("g3d.valid_end", 32'(tif.tid_valid), 0);
    do_clr();
    check_idle("g3d.clr");

    // Stall while TID 7 is offered
    configure(15, 3, 1, 1);
    step();
`ifdef DICE_DISP_PERF_CNT_EN
    check("stall.perf_pre", perf_stall_cycles, 0);
`endif
    step(7);
    check_offer("stall.pre", 7, 3, 1, 0, 1'b1);
    tif.tid_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      check_offer($sformatf("stall%0d", i), 7, 3, 1, 0, 1'b1);
    end
    tif.tid_ready = 1'b1;
    step();
    check_offer("stall.post", 8, 0, 0, 1, 1'b1);
`ifdef DICE_DISP_PERF_CNT_EN
    check("stall.perf_stall", perf_stall_cycles, 4);
    check("stall.perf_active", perf_active_cycles, 12);
`endif
    do_clr();
    check_idle("stall.clr");

    // Pause on TID 20 (5x5x2 grid), then a handshake on the falling-enable cycle
    configure(40, 4, 4, 1);
    step();
    step(20);
    check_offer("pause.pre", 20, 0, 4, 0, 1'b1);
    enable = 1'b0;
    tif.tid_ready = 1'b0;
    step();
    check_offer("pause.off1", 20, 0, 4, 0, 1'b0);
    step();
    check_offer("pause.off2", 20, 0, 4, 0, 1'b0);
    enable = 1'b1;
    step();
    check_offer("pause.resume", 20, 0, 4, 0, 1'b1);
    tif.tid_ready = 1'b1;
    step();
    check_offer("pause.next", 21, 1, 4, 0, 1'b1);
    enable = 1'b0;
    step();
    check_offer("fall.accepted", 22, 2, 4, 0, 1'b0);
    enable = 1'b1;
    step();
    check_offer("fall.resume", 22, 2, 4, 0, 1'b1);
    do_clr();
    check_idle("pause.clr");

    // Single-thread CTA, then restart after clr
    configure(0, 0, 0, 0);
    step();
    check_offer("one.offer", 0, 0, 0, 0, 1'b1);
    step();
    check("one.done", 32'(done), 1);
    check("one.valid", 32'(tif.tid_valid), 0);
    do_clr();
    check_idle("one.clr");
    step();
    check_offer("one.restart", 0, 0, 0, 0, 1'b1);
    do_clr();

    // Reset while TID 100 is pending
    configure(200, 255, 0, 0);
    step(101);
    tif.tid_ready = 1'b0;
    check_offer("rst.pending", 100, 100, 0, 0, 1'b1);
    rst = 1'b1;
    step();
    check_idle("rst.mid");
`ifdef DICE_DISP_PERF_CNT_EN
    check("rst.perf_active", perf_active_cycles, 0);
`endif
    rst = 1'b0;
    step();
    check_offer("rst.restart", 0, 0, 0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dice_tid_dispatcher.md
Name: dice_tid_dispatcher

Overview:
- Upstream thread-issue stage for dice_cgra_subsystem.
- Emits one linear thread ID per accepted handshake, together with its decomposed (x,y,z) coordinates, for a CTA of up to NUM_TID threads.
- Replaces the free-running naive dispatcher with valid/ready backpressure, so the subsystem can stall issue when its RF/IO pipeline is full.
- Signals done once the last thread has been accepted.

Parameters:
- NUM_TID, 512, maximum threads per CTA.
- TID_WIDTH, $clog2(NUM_TID), width of all TID and coordinate fields.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- enable  in  1  start/continue dispatch; sampled in IDLE and RUN.
- clr  in  1  synchronous soft clear; returns to IDLE.
- max_tid  in  TID_WIDTH  last linear TID to issue (inclusive).
- ntid_x  in  TID_WIDTH  last x index (dimension size minus 1).
- ntid_y  in  TID_WIDTH  last y index (dimension size minus 1).
- ntid_z  in  TID_WIDTH  last z index (dimension size minus 1).
- dispatch_tid  out  TID_WIDTH  linear TID of the current offer.
- tid_x  out  TID_WIDTH  x coordinate of dispatch_tid.
- tid_y  out  TID_WIDTH  y coordinate of dispatch_tid.
- tid_z  out  TID_WIDTH  z coordinate of dispatch_tid.
- tid_valid  out  1  offer valid.
- tid_ready  in  1  consumer accepts this cycle.
- done  out  1  all TIDs 0..max_tid accepted; sticky until clr/rst.

Behaviour:
- Reset (rst=1) and clr=1 have identical effect:
  - state=IDLE;
  - dispatch_tid, tid_x, tid_y, tid_z = 0;
  - tid_valid=0, done=0.
  - rst takes priority over clr; clr takes priority over every other input.
- Configuration sampling: max_tid and ntid_* are sampled only on the IDLE->RUN transition and held internally; later input changes are ignored until the next IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - enable=1 -> RUN, with tid_valid=1 and TID 0 (coordinates 0,0,0) presented in the next cycle.
  - enable=0 -> stay in IDLE.
- RUN, offer held:
  - All outputs are registered.
  - While tid_valid=1 and tid_ready=0, dispatch_tid and tid_x/y/z hold stable. This is the AXI-style rule: no retraction, no change.
- RUN, handshake (tid_valid & tid_ready):
  - If dispatch_tid == max_tid: tid_valid=0 next cycle, done=1 next cycle, go to DONE.
  - Otherwise advance next cycle, giving 1 TID/cycle throughput under continuous ready:
    - dispatch_tid+1;
    - tid_x+1 if tid_x<ntid_x, else tid_x=0 and carry into y;
    - y wraps at ntid_y and carries into z the same way;
    - z wraps at ntid_z to 0 (wrap without error).
- Coordinate arithmetic: computed by incrementing counters only, with no divide or modulo. The consumer is responsible for the invariant linear = x + (ntid_x+1)*(y + (ntid_y+1)*z).
- RUN with enable=0: pause. tid_valid drops to 0 next cycle and counters hold. When enable returns to 1, tid_valid=1 again with the same un-accepted TID.
- A handshake in the cycle enable falls is still honoured.
- DONE: done=1 and tid_valid=0 until clr or rst. enable is ignored.
- Boundary: max_tid=0 issues exactly one TID, then DONE.
- Boundary: max_tid=NUM_TID-1 issues the full range without TID_WIDTH overflow; the counter never increments past max_tid.
- Reset mid-operation: any in-flight offer is dropped; no partial state survives.

Optional Feature:
- Macro: DICE_DISP_PERF_CNT_EN.
- Defined: adds two outputs, each 32-bit saturating and cleared on rst/clr:
  - perf_stall_cycles: counts cycles with tid_valid=1 and tid_ready=0.
  - perf_active_cycles: counts cycles in RUN.
- Undefined: these ports and their logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package dice_disp_pkg holds:
  - disp_state_e enum (IDLE, RUN, DONE);
  - a TID_WIDTH-derived typedef tid_t;
  - the perf counter width constant.
- One sub-module, dice_tid_counter3d: the x/y/z wrap-and-carry counter with inputs inc, clear, and the three limits.

Test Plan:
- max_tid=255, ntid_x=255, ntid_y=ntid_z=0, tid_ready=1 -> TIDs 0..255 on consecutive cycles; tid_x=TID, y=z=0; done asserts the cycle after TID 255 is accepted.
- ntid_x=3, ntid_y=1, ntid_z=1, max_tid=15 -> TID 5 gives (1,1,0), TID 13 gives (1,1,1), TID 15 gives (3,1,1), then done.
- tid_ready low for 4 cycles while TID 7 is offered -> TID 7 and its coordinates stay stable; TID 8 follows the cycle after ready rises. With DICE_DISP_PERF_CNT_EN, perf_stall_cycles=4.
- enable dropped during TID 20 (not accepted) -> tid_valid=0; re-enable -> TID 20 re-offered, with no TID skipped or duplicated.
- max_tid=0 -> a single TID 0 handshake, then done; clr -> IDLE with all outputs 0; enable -> restarts at TID 0.
- rst pulsed while TID 100 is pending -> all outputs 0 the next cycle and state IDLE.
